ex_stage_unit: RTL and testbench

Execute-stage block of the 64-bit RISC-V pipeline. It combines the ALU, the PC+4 incrementer and the branch-target adder in one unit, and resolves conditional branches. All results are captured in an EX/MEM pipeline register. The block sits between the ID/EX register (register bank, immediate generator and control unit outputs) and the data-memory stage, and it feeds the next-PC select back to fetch.

---
 rtl/ex_pkg.sv | 14 +
 rtl/ex_alu.sv | 32 +++
 rtl/ex_stage_unit.sv | 70 +++++++
 tb/tb_ex_stage_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and constants for the execute stage
package ex_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int PC_STEP      = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU with zero flag
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    alu_op_t op_e;

    assign op_e = alu_op_t'(op);

    // Select the operation; arithmetic wraps and carries are dropped
    always_comb begin
        result = '0;
        case (op_e)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_unit.sv
// rtl/ex_stage_unit.sv - execute stage: ALU, PC adders, BEQ resolve, EX/MEM register
module ex_stage_unit
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic            branch,
    output logic [XLEN-1:0] next_pc,
    output logic            take_branch,
    output logic [XLEN-1:0] alu_result_q,
    output logic            zero_q,
    output logic [XLEN-1:0] store_data_q,
    output logic [XLEN-1:0] pc_plus4_q,
    output logic            valid_q
);

    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic            live;

    assign operand_b = alu_src ? imm : rs2_data;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .a      (rs1_data),
        .b      (operand_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (zero)
    );

    // Both adders wrap modulo 2^XLEN; the shift drops the immediate's top bit
    assign pc_plus4      = pc + XLEN'(PC_STEP);
    assign branch_target = pc + (imm << 1);

    // A flushed or empty slot can never redirect fetch
    assign live        = valid_in & ~flush;
    assign take_branch = branch & zero & live;
    assign next_pc     = take_branch ? branch_target : pc_plus4;

    // EX/MEM register: results load every cycle, valid gates their use downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            zero_q       <= 1'b1;
            store_data_q <= '0;
            pc_plus4_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            alu_result_q <= alu_result;
            zero_q       <= zero;
            store_data_q <= rs2_data;
            pc_plus4_q   <= pc_plus4;
            valid_q      <= live;
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// tb/tb_ex_stage_unit.sv - self-checking bench for ex_stage_unit
module tb_ex_stage_unit;
    import ex_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        flush;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        branch;
    logic [63:0] next_pc;
    logic        take_branch;
    logic [63:0] alu_result_q;
    logic        zero_q;
    logic [63:0] store_data_q;
    logic [63:0] pc_plus4_q;
    logic        valid_q;

    int n_pass;
    int n_total;

    ex_stage_unit #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .flush        (flush),
        .pc           (pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .branch       (branch),
        .next_pc      (next_pc),
        .take_branch  (take_branch),
        .alu_result_q (alu_result_q),
        .zero_q       (zero_q),
        .store_data_q (store_data_q),
        .pc_plus4_q   (pc_plus4_q),
        .valid_q      (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic        src;
        logic [1:0]  op;
        logic        br;
        logic        vld;
        logic        fl;
        logic [63:0] exp_res;
        logic        exp_zero;
        logic        exp_take;
        logic [63:0] exp_next;
        logic [63:0] exp_pc4;
        logic        exp_vq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic s, input logic [1:0] o,
                         input logic br, input logic v, input logic f);
        pc = p; rs1_data = a; rs2_data = b; imm = im;
        alu_src = s; alu_op = o; branch = br; valid_in = v; flush = f;
    endtask

    function automatic vec_t model(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] im, input logic s, input logic [1:0] o,
                                   input logic br, input logic v, input logic f);
        vec_t r;
        logic [63:0] opb;
        r.pc = p; r.rs1 = a; r.rs2 = b; r.imm = im; r.src = s; r.op = o;
        r.br = br; r.vld = v; r.fl = f;
        opb = s ? im : b;
        if (o == 2'd0)      r.exp_res = a + opb;
        else if (o == 2'd1) r.exp_res = a - opb;
        else if (o == 2'd2) r.exp_res = a & opb;
        else                r.exp_res = a | opb;
        r.exp_zero = (r.exp_res == 64'd0);
        r.exp_take = br && r.exp_zero && v && !f;
        r.exp_pc4  = p + 64'd4;
        r.exp_next = r.exp_take ? p + im * 64'd2 : r.exp_pc4;
        r.exp_vq   = v && !f;
        return r;
    endfunction

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.pc, t.rs1, t.rs2, t.imm, t.src, t.op, t.br, t.vld, t.fl);
        #1;
        check({tag, " take_branch"}, 64'(take_branch), 64'(t.exp_take));
        check({tag, " next_pc"}, next_pc, t.exp_next);
        @(posedge clk);
        #1;
        check({tag, " alu_result_q"}, alu_result_q, t.exp_res);
        check({tag, " zero_q"}, 64'(zero_q), 64'(t.exp_zero));
        check({tag, " store_data_q"}, store_data_q, t.rs2);
        check({tag, " pc_plus4_q"}, pc_plus4_q, t.exp_pc4);
        check({tag, " valid_q"}, 64'(valid_q), 64'(t.exp_vq));
    endtask

    function automatic vec_t mk(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] im, input logic s, input logic [1:0] o,
                                input logic br, input logic v, input logic f,
                                input logic [63:0] res, input logic z, input logic tk,
                                input logic [63:0] nx, input logic [63:0] p4, input logic vq);
        vec_t r;
        r.pc = p; r.rs1 = a; r.rs2 = b; r.imm = im; r.src = s; r.op = o;
        r.br = br; r.vld = v; r.fl = f;
        r.exp_res = res; r.exp_zero = z; r.exp_take = tk;
        r.exp_next = nx; r.exp_pc4 = p4; r.exp_vq = vq;
        return r;
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Hand-built expectations from the worked examples
        vecs.push_back(mk(64'h0,   64'd5,  64'd0,  64'd7, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0,
                          64'd12, 1'b0, 1'b0, 64'h4, 64'h4, 1'b1));
        vecs.push_back(mk(64'h0,   64'h0F, 64'h3C, 64'd0, 1'b0, ALU_AND, 1'b0, 1'b1, 1'b0,
                          64'h0C, 1'b0, 1'b0, 64'h4, 64'h4, 1'b1));
        vecs.push_back(mk(64'h0,   64'h0F, 64'h3C, 64'd0, 1'b0, ALU_OR,  1'b0, 1'b1, 1'b0,
                          64'h3F, 1'b0, 1'b0, 64'h4, 64'h4, 1'b1));
        vecs.push_back(mk(64'h0,   64'd0,  64'd1,  64'd0, 1'b0, ALU_SUB, 1'b0, 1'b1, 1'b0,
                          ONES, 1'b0, 1'b0, 64'h4, 64'h4, 1'b1));
        vecs.push_back(mk(64'h0,   ONES,   64'd1,  64'd0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b0,
                          64'd0, 1'b1, 1'b0, 64'h4, 64'h4, 1'b1));
        vecs.push_back(mk(64'h100, 64'd9,  64'd9,  64'd8, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0,
                          64'd0, 1'b1, 1'b1, 64'h110, 64'h104, 1'b1));
        vecs.push_back(mk(64'h100, 64'd9,  64'd10, 64'd8, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0,
                          ONES, 1'b0, 1'b0, 64'h104, 64'h104, 1'b1));
        vecs.push_back(mk(64'h100, 64'd9,  64'd9,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0,
                          64'd0, 1'b1, 1'b1, 64'hF8, 64'h104, 1'b1));
        vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 64'd0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b0,
                          64'd3, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1));
        vecs.push_back(mk(64'h100, 64'd9,  64'd9,  64'd8, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b1,
                          64'd0, 1'b1, 1'b0, 64'h104, 64'h104, 1'b0));
        vecs.push_back(mk(64'h100, 64'd9,  64'd9,  64'd8, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0,
                          64'd0, 1'b1, 1'b0, 64'h104, 64'h104, 1'b0));

        // Load live state first so the asynchronous reset has something to clear
        rst_n = 1'b1;
        drive(64'h40, 64'd5, 64'd3, 64'd7, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset alu_result_q", alu_result_q, 64'd0);
        check("reset zero_q", 64'(zero_q), 64'd1);
        check("reset store_data_q", store_data_q, 64'd0);
        check("reset pc_plus4_q", pc_plus4_q, 64'd0);
        check("reset valid_q", 64'(valid_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a valid stream drops the captured instruction
        apply(vecs[0], "pre_midreset");
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset valid_q", 64'(valid_q), 64'd0);
        check("midreset alu_result_q", alu_result_q, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(vecs[5], "post_midreset");

        // Randomized traffic against the arithmetic reference
        for (int i = 0; i < 300; i++) begin
            logic [63:0] p, a, b, im;
            logic [1:0]  o;
            logic        s, br, v, f;
            p  = {$urandom, $urandom};
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
            im = {$urandom, $urandom};
            o  = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 4) != 0);
            f  = ($urandom_range(0, 3) == 0);
            if (br && $urandom_range(0, 1) == 1) begin
                o = ALU_SUB;
                s = 1'b0;
            end
            apply(model(p, a, b, im, s, o, br, v, f), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
